// File: rtl/batch_sched_fxp.sv
// Batch scheduler / result combiner for the two-stage batch control-bounded filter.
// Optional feature macro: BATCH_SCHED_SAT_EN (saturating combine + sticky sat_flag).
module batch_sched_fxp #(
   parameter int M         = 4,
   parameter int DSR1      = 2,
   parameter int DSR2      = 6,
   parameter int MAX_DEPTH = 32,
   parameter int OUT_WIDTH = 14,
   parameter int RES_DELAY = 3,
   localparam int SW = M*DSR1,
   localparam int AS = $clog2(4*MAX_DEPTH*DSR2),
   localparam int AR = $clog2(2*MAX_DEPTH),
   localparam int LW = $clog2(MAX_DEPTH+1)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [M-1:0]         in,
   input  logic [LW-1:0]        batch_len,
   output logic                 smp_we,
   output logic [SW-1:0]        smp_wdata,
   output logic [AS-1:0]        smp_waddr,
   output logic [AS-1:0]        smp_raddr_lh,
   output logic [AS-1:0]        smp_raddr_f,
   output logic [AS-1:0]        smp_raddr_b,
   output logic                 ds_en,
   output logic                 rec_valid,
   input  logic [OUT_WIDTH-1:0] res_f,
   input  logic [OUT_WIDTH-1:0] res_b,
   output logic                 res_we,
   output logic [AR-1:0]        res_waddr,
   output logic [AR-1:0]        res_raddr_f,
   output logic [AR-1:0]        res_raddr_b,
   output logic [OUT_WIDTH-1:0] res_wdata_f,
   output logic [OUT_WIDTH-1:0] res_wdata_b,
   input  logic [OUT_WIDTH-1:0] res_rdata_f,
   input  logic [OUT_WIDTH-1:0] res_rdata_b,
   output logic [OUT_WIDTH-1:0] out,
   output logic                 out_valid,
   output logic                 valid,
   output logic                 sat_flag
);
   localparam int IW  = AS-2;
   localparam int KW  = AR-1;
   localparam int P1W = (DSR1 > 1) ? $clog2(DSR1) : 1;
   localparam int P2W = (DSR2 > 1) ? $clog2(DSR2) : 1;

   logic [P1W-1:0] p1;
   logic [P2W-1:0] p2;
   logic [KW-1:0]  k;
   logic [1:0]     cyc;
   logic [LW-1:0]  L, len_c;
   logic [2:0]     bcnt;
   logic [SW-1:0]  acc, word_c;
   logic [IW-1:0]  fwd, rev;
   logic           k_end, last1;
   logic [1:0]     vld_pipe;   // [0]: result write stage, [1]: read data valid
   logic [RES_DELAY-1:0][KW-1:0] kd_p;
   logic [RES_DELAY-1:0][LW-1:0] ld_p;
   logic [RES_DELAY-1:0]         bd_p;
   logic [KW-1:0]  kd;
   logic [LW-1:0]  ld;
   logic           bd;
   logic [OUT_WIDTH-1:0] res_c;

   assign last1     = (p1 == P1W'(DSR1-1));
   assign ds_en     = last1 && (p2 == P2W'(DSR2-1));
   assign k_end     = (LW'(k) == L - LW'(1));
   assign fwd       = IW'(DSR2*int'(k) + int'(p2));
   assign rev       = IW'(int'(L)*DSR2 - 1) - fwd;
   assign rec_valid = (bcnt >= 3'd3);
   assign valid     = (bcnt >= 3'd5);
   assign res_we    = vld_pipe[0];
   assign kd        = kd_p[RES_DELAY-1];
   assign ld        = ld_p[RES_DELAY-1];
   assign bd        = bd_p[RES_DELAY-1];

   always_comb begin
      len_c = batch_len;
      if (batch_len < LW'(2))              len_c = LW'(2);
      else if (batch_len > LW'(MAX_DEPTH)) len_c = LW'(MAX_DEPTH);
   end

   // current slice merged in so the completed word includes this clk's input
   always_comb begin
      word_c = acc;
      word_c[p1*M +: M] = in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1 <= '0; p2 <= '0; k <= '0; cyc <= '0; bcnt <= '0;
         L <= LW'(MAX_DEPTH);
         acc <= '0; smp_we <= 1'b0; smp_wdata <= '0;
         smp_waddr <= '0; smp_raddr_lh <= '0; smp_raddr_f <= '0; smp_raddr_b <= '0;
      end else begin
         acc    <= word_c;
         smp_we <= 1'b0;
         if (last1) begin
            p1           <= '0;
            p2           <= (p2 == P2W'(DSR2-1)) ? '0 : p2 + P2W'(1);
            smp_we       <= 1'b1;
            smp_wdata    <= word_c;
            smp_waddr    <= {fwd, cyc};
            smp_raddr_f  <= {fwd, cyc + 2'd1};
            smp_raddr_b  <= {rev, cyc + 2'd1};
            smp_raddr_lh <= {rev, cyc + 2'd3};
         end else begin
            p1 <= p1 + P1W'(1);
         end
         if (ds_en) begin
            if (k_end) begin
               k   <= '0;
               cyc <= cyc + 2'd1;
               L   <= len_c;
               // a length change flushes the pipeline validity
               if (len_c != L)          bcnt <= '0;
               else if (bcnt != 3'd5)   bcnt <= bcnt + 3'd1;
            end else begin
               k <= k + KW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         kd_p <= '0; bd_p <= '0;
         ld_p <= {RES_DELAY{LW'(MAX_DEPTH)}};
         res_waddr <= '0; res_raddr_f <= '0; res_raddr_b <= '0;
         res_wdata_f <= '0; res_wdata_b <= '0;
         out <= '0; out_valid <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[0], ds_en};
         if (ds_en) begin
            for (int i = RES_DELAY-1; i > 0; i--) begin
               kd_p[i] <= kd_p[i-1];
               ld_p[i] <= ld_p[i-1];
               bd_p[i] <= bd_p[i-1];
            end
            kd_p[0]     <= k;
            ld_p[0]     <= L;
            bd_p[0]     <= cyc[0];
            res_waddr   <= {kd, bd};
            res_raddr_f <= {kd, ~bd};
            res_raddr_b <= {KW'(ld - LW'(1) - LW'(kd)), ~bd};
            res_wdata_f <= res_f;
            res_wdata_b <= res_b;
         end
         if (vld_pipe[1]) out <= {~res_c[OUT_WIDTH-1], res_c[OUT_WIDTH-2:0]};
         out_valid <= vld_pipe[1] & valid;
      end
   end

`ifdef BATCH_SCHED_SAT_EN
   logic [OUT_WIDTH:0] sum;
   logic               sat_hit;
   assign sum     = {res_rdata_f[OUT_WIDTH-1], res_rdata_f} + {res_rdata_b[OUT_WIDTH-1], res_rdata_b};
   assign sat_hit = sum[OUT_WIDTH] ^ sum[OUT_WIDTH-1];
   always_comb begin
      res_c = sum[OUT_WIDTH-1:0];
      if (sat_hit) res_c = {sum[OUT_WIDTH], {(OUT_WIDTH-1){~sum[OUT_WIDTH]}}};
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sat_flag <= 1'b0;
      else      sat_flag <= sat_flag | (vld_pipe[1] & sat_hit);
   end
`else
   assign res_c    = res_rdata_f + res_rdata_b;
   assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_batch_sched_fxp.sv
// Directed bench for batch_sched_fxp: strobes, addressing, validity, length change, combine, reset.
module tb_batch_sched_fxp;
   localparam int M = 2, DSR1 = 2, DSR2 = 3, MAX_DEPTH = 8, OUT_WIDTH = 14;
   localparam int SW = 4, AS = 7, AR = 4, LW = 4;

   logic                 clk, rst;
   logic [M-1:0]         in;
   logic [LW-1:0]        batch_len;
   logic                 smp_we, ds_en, rec_valid, res_we, out_valid, valid, sat_flag;
   logic [SW-1:0]        smp_wdata;
   logic [AS-1:0]        smp_waddr, smp_raddr_lh, smp_raddr_f, smp_raddr_b;
   logic [OUT_WIDTH-1:0] res_f, res_b, res_wdata_f, res_wdata_b, res_rdata_f, res_rdata_b, out;
   logic [AR-1:0]        res_waddr, res_raddr_f, res_raddr_b;
   logic                 ph;
   int total = 0, bad = 0;

   batch_sched_fxp #(.M(M), .DSR1(DSR1), .DSR2(DSR2), .MAX_DEPTH(MAX_DEPTH),
                     .OUT_WIDTH(OUT_WIDTH), .RES_DELAY(3)) dut (
      .clk(clk), .rst(rst), .in(in), .batch_len(batch_len),
      .smp_we(smp_we), .smp_wdata(smp_wdata), .smp_waddr(smp_waddr),
      .smp_raddr_lh(smp_raddr_lh), .smp_raddr_f(smp_raddr_f), .smp_raddr_b(smp_raddr_b),
      .ds_en(ds_en), .rec_valid(rec_valid), .res_f(res_f), .res_b(res_b),
      .res_we(res_we), .res_waddr(res_waddr), .res_raddr_f(res_raddr_f),
      .res_raddr_b(res_raddr_b), .res_wdata_f(res_wdata_f), .res_wdata_b(res_wdata_b),
      .res_rdata_f(res_rdata_f), .res_rdata_b(res_rdata_b), .out(out),
      .out_valid(out_valid), .valid(valid), .sat_flag(sat_flag));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one clk; inputs follow the slice phase (01 at p1=0, 10 at p1=1)
   task automatic tick;
      @(posedge clk); #1;
      ph = ~ph;
      in = ph ? 2'b10 : 2'b01;
   endtask

   initial begin
      rst = 1'b1; ph = 1'b0; in = 2'b01; batch_len = 4'd8;
      res_f = 14'h0ABC; res_b = 14'h1234; res_rdata_f = '0; res_rdata_b = '0;
      #2 rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_smp_we",    32'(smp_we), 0);
      chk("rst_ds_en",     32'(ds_en), 0);
      chk("rst_valid",     32'(valid), 0);
      chk("rst_rec_valid", 32'(rec_valid), 0);
      chk("rst_out",       32'(out), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_sat",       32'(sat_flag), 0);
      chk("rst_raddr_b",   32'(smp_raddr_b), 0);
      chk("rst_res_we",    32'(res_we), 0);
      rst = 1'b1;

      for (int c = 0; c <= 420; c++) begin
         if (c < 60) begin
            chk("smp_we", 32'(smp_we), 32'((c >= 2) && (c % 2 == 0)));
            chk("ds_en",  32'(ds_en),  32'(c % 6 == 5));
         end
         if (c >= 2 && c <= 48 && c % 2 == 0) begin
            chk("waddr_b0", 32'(smp_waddr), ((c-2)/2)*4);
            chk("wdata",    32'(smp_wdata), 32'h9);
         end
         case (c)
            2: begin
               chk("raddr_f0",  32'(smp_raddr_f), 1);
               chk("raddr_b0",  32'(smp_raddr_b), 93);
               chk("raddr_lh0", 32'(smp_raddr_lh), 95);
            end
            6: begin
               chk("res_we",     32'(res_we), 1);
               chk("res_wd_f",   32'(res_wdata_f), 32'h0ABC);
               chk("res_wd_b",   32'(res_wdata_b), 32'h1234);
               chk("res_waddr0", 32'(res_waddr), 0);
               chk("res_rf0",    32'(res_raddr_f), 1);
               chk("res_rb0",    32'(res_raddr_b), 15);
               res_rdata_f = 14'h0100; res_rdata_b = 14'h0023;
            end
            7:  chk("res_we_lo", 32'(res_we), 0);
            8: begin
               chk("out_a",    32'(out), 32'h2123);
               chk("ov_noval", 32'(out_valid), 0);
            end
            12: begin res_rdata_f = 14'h3000; res_rdata_b = 14'h0FFF; end
            14: chk("out_neg1", 32'(out), 32'h1FFF);
            18: begin res_rdata_f = 14'h0FFF; res_rdata_b = 14'h1000; end
            20: begin
               chk("out_max", 32'(out), 32'h3FFF);
               chk("sat_pre", 32'(sat_flag), 0);
            end
            24: begin res_rdata_f = 14'h1FFF; res_rdata_b = 14'h1FFF; end
            26: begin
`ifdef BATCH_SCHED_SAT_EN
               chk("out_sat", 32'(out), 32'h3FFF);
               chk("sat_set", 32'(sat_flag), 1);
`else
               chk("out_wrap", 32'(out), 32'h1FFE);
               chk("sat_off",  32'(sat_flag), 0);
`endif
            end
            30: begin
               chk("res_waddr1", 32'(res_waddr), 2);
               chk("res_rb1",    32'(res_raddr_b), 13);
               res_rdata_f = '0; res_rdata_b = '0;
            end
            32: begin
               chk("out_zero", 32'(out), 32'h2000);
`ifdef BATCH_SCHED_SAT_EN
               chk("sat_hold", 32'(sat_flag), 1);
`else
               chk("sat_hold", 32'(sat_flag), 0);
`endif
            end
            50: begin
               chk("waddr_b1",  32'(smp_waddr), 1);
               chk("raddr_lh1", 32'(smp_raddr_lh), 92);
            end
            72: begin
               chk("res_waddr2", 32'(res_waddr), 1);
               chk("res_rf2",    32'(res_raddr_f), 0);
               chk("res_rb2",    32'(res_raddr_b), 14);
            end
            143: chk("recv_pre",  32'(rec_valid), 0);
            144: chk("recv_rise", 32'(rec_valid), 1);
            239: chk("val_pre",   32'(valid), 0);
            240: chk("val_rise",  32'(valid), 1);
            247: chk("ov_pre",    32'(out_valid), 0);
            248: chk("ov_pulse",  32'(out_valid), 1);
            249: chk("ov_post",   32'(out_valid), 0);
            250: batch_len = 4'd4;
            287: chk("val_hold",  32'(valid), 1);
            288: begin
               chk("val_flush",  32'(valid), 0);
               chk("recv_flush", 32'(rec_valid), 0);
            end
            290: chk("raddr_b_l4", 32'(smp_raddr_b), 47);
            359: chk("recv_pre4",  32'(rec_valid), 0);
            360: chk("recv_rise4", 32'(rec_valid), 1);
            407: chk("val_pre4",   32'(valid), 0);
            408: chk("val_rise4",  32'(valid), 1);
            default: ;
         endcase
         if (c < 420) tick;
      end

      chk("pre_rst_valid", 32'(valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out",     32'(out), 0);
      chk("mid_rst_valid",   32'(valid), 0);
      chk("mid_rst_recv",    32'(rec_valid), 0);
      chk("mid_rst_ov",      32'(out_valid), 0);
      chk("mid_rst_we",      32'(smp_we), 0);
      chk("mid_rst_wdata",   32'(smp_wdata), 0);
      chk("mid_rst_waddr",   32'(smp_waddr), 0);
      chk("mid_rst_raddr_b", 32'(smp_raddr_b), 0);
      chk("mid_rst_res_rb",  32'(res_raddr_b), 0);
      chk("mid_rst_res_we",  32'(res_we), 0);
      chk("mid_rst_sat",     32'(sat_flag), 0);
      chk("mid_rst_ds",      32'(ds_en), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
